// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 WIDTH-bit mux path.
//   Four requesters offer words with req/gnt; one is picked per transfer,
//   its word is registered and handed downstream on valid/ready.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        req[i]=1: requester i has word i valid
//   in_data    word i = in_data[i*WIDTH +: WIDTH]
//   gnt        one-hot, combinational; gnt[i]=1: word i captured at this edge
//   sel        index of the last granted requester
//   out_valid  out_data holds an unconsumed word
//   out_data   registered muxed word
//   out_ready  consumer accepts out_data when out_valid && out_ready
module rr_mux_arbiter #(
   parameter int WIDTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] in_data,
   output logic [3:0]         gnt,
   output logic [1:0]         sel,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   input  logic               out_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr;
   logic [1:0] winner;
   logic [1:0] idx;
   logic       found;
   logic       load;

   // Scan ptr, ptr+1, ... (2-bit wrap) and keep the first requester seen.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // A word is loaded when the output register is free (or being drained
   // this cycle) and anyone is requesting.
   always_comb begin
      load      = (state == IDLE || out_ready) && (|req) && !rst;
      gnt       = '0;
      state_nxt = state;
      if (load) begin
         gnt[winner] = 1'b1;
         state_nxt   = FULL;
      end else if (state == FULL && out_ready) begin
         state_nxt = IDLE;
      end
   end

   assign out_valid = (state == FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         out_data <= '0;
         sel      <= '0;
         ptr      <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            out_data <= in_data[int'(winner)*WIDTH +: WIDTH];
            sel      <= winner;
            ptr      <= winner + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req;
   logic [4*W-1:0] in_data;
   logic [3:0]     gnt;
   logic [1:0]     sel;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_ready;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // reference model state
   int unsigned m_ptr, m_sel, m_data;
   bit          m_valid;
   logic [3:0]  last_gnt;
   int unsigned exp_gnt;

   // requester stimulus state
   bit          pend [4];
   int unsigned pword[4];

   always #5 clk = ~clk;

   rr_mux_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .in_data   (in_data),
      .gnt       (gnt),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned word_of(input logic [4*W-1:0] d, input int unsigned i);
      logic [4*W-1:0] t;
      t = d >> (i * W);
      return int'(t) % (1 << W);
   endfunction

   function automatic logic [4*W-1:0] pack_words(input int unsigned w0, input int unsigned w1,
                                                input int unsigned w2, input int unsigned w3);
      logic [4*W-1:0] d;
      d = '0;
      d = d | (4*W)'(w0 % (1 << W));
      d = d | ((4*W)'(w1 % (1 << W)) << W);
      d = d | ((4*W)'(w2 % (1 << W)) << (2*W));
      d = d | ((4*W)'(w3 % (1 << W)) << (3*W));
      return d;
   endfunction

   // One clock: called just after a falling edge with inputs already driven.
   task automatic cycle();
      bit          ld;
      int unsigned win;
      bit          found;
      #1;
      ld  = !rst && (!m_valid || out_ready) && (req != 4'b0000);
      win = 0;
      found = 0;
      for (int k = 0; k < 4; k++) begin
         if (!found && req[(m_ptr + k) % 4]) begin
            win   = (m_ptr + k) % 4;
            found = 1;
         end
      end
      exp_gnt  = ld ? (1 << win) : 0;
      last_gnt = gnt;
      chk("gnt", gnt, exp_gnt);
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
      end else if (ld) begin
         m_data  = word_of(in_data, win);
         m_sel   = win;
         m_ptr   = (win + 1) % 4;
         m_valid = 1;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      #1;
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("sel", sel, m_sel);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      m_ptr = 0; m_sel = 0; m_data = 0; m_valid = 0;
      rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
      in_data = pack_words(0, 1, 2, 3);
      @(negedge clk);

      // 1. reset with everything requesting
      repeat (2) cycle();
      chk("rst_gnt", last_gnt, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sel", sel, 0);

      // 2. single request
      rst = 1'b0; req = 4'b0100; in_data = pack_words(0, 0, 2'b10, 0);
      cycle();
      chk("single_gnt", last_gnt, 4'b0100);
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 2'b10);
      chk("single_sel", sel, 2);
      req = 4'b0000;
      cycle();
      chk("drain_valid", out_valid, 0);
      chk("drain_data_hold", out_data, 2'b10);

      // 3. rotation from ptr=0
      rst = 1'b1; cycle(); rst = 1'b0;
      req = 4'b1111; in_data = pack_words(0, 1, 2, 3);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("rot_gnt", last_gnt, 1 << (i % 4));
         chk("rot_data", out_data, i % 4);
      end

      // 4. backpressure (ptr=1, holding word 0)
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_gnt", last_gnt, 0);
         chk("bp_data", out_data, 0);
         chk("bp_sel", sel, 0);
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_release_gnt", last_gnt, 4'b0010);
      chk("bp_release_data", out_data, 1);

      // 5. pointer skip/wrap with ptr=2
      req = 4'b0011;
      cycle();
      chk("wrap_gnt", last_gnt, 4'b0001);
      req = 4'b0010;
      cycle();
      chk("skip_gnt", last_gnt, 4'b0010);

      // 6. reset mid-operation
      req = 4'b1000;
      cycle();
      chk("pre_rst_data", out_data, 2'b11);
      rst = 1'b1; req = 4'b1111;
      cycle();
      chk("mid_rst_valid", out_valid, 0);
      rst = 1'b0;
      cycle();
      chk("post_rst_gnt", last_gnt, 4'b0001);

      // randomized traffic with well-behaved requesters
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0; pword[i] = 0;
      end
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && ($urandom % 3 == 0)) begin
               pend[i]  = 1;
               pword[i] = $urandom % (1 << W);
            end
         end
         for (int i = 0; i < 4; i++) req[i] = pend[i];
         in_data   = pack_words(pword[0], pword[1], pword[2], pword[3]);
         out_ready = ($urandom % 10) < 7;
         rst       = ($urandom % 250) == 0;
         cycle();
         for (int i = 0; i < 4; i++)
            if (exp_gnt[i]) pend[i] = ($urandom % 2 == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
